// File: rtl/i2c_target.sv
// i2c_target: I2C responder. Detects START/Sr/STOP, matches a 7-bit address, loads an
// 8-bit register pointer, then streams write bytes out (wr_en) or read bytes in (rd_strobe).
// SDA is open-drain: the target only ever pulls it low.
//   i_clk, i_rst     system clock, synchronous active-high reset
//   i_scl, io_sda    I2C bus (asynchronous to i_clk)
//   o_reg_addr       register pointer
//   o_wr_en/o_wr_data  one-cycle write strobe with received byte
//   i_rd_data/o_rd_strobe  read data, captured while o_rd_strobe=1
//   o_busy           addressed and in a transaction
module i2c_target #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h68,
    parameter int unsigned AUTO_INC   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic [7:0] o_reg_addr,
    output logic       o_wr_en,
    output logic [7:0] o_wr_data,
    input  logic [7:0] i_rd_data,
    output logic       o_rd_strobe,
    output logic       o_busy
);

    localparam logic [7:0] ADDR_STEP = (AUTO_INC != 0) ? 8'd1 : 8'd0;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_A_ACK, S_REG, S_R_ACK,
        S_WDATA, S_W_ACK, S_RDATA, S_M_ACK, S_IGNORE
    } state_t;

    state_t     r_state, w_state;

    logic       r_scl_s1, r_scl_s2, r_scl_h;
    logic       r_sda_s1, r_sda_s2, r_sda_h;
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_tx, w_tx;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic       r_byte_done, w_byte_done;
    logic       r_rw, w_rw;
    logic       r_sda_low, w_sda_low;
    logic       r_busy, w_busy;
    logic [7:0] r_reg_addr, w_reg_addr;
    logic [7:0] r_wr_data, w_wr_data;
    logic       r_wr_en, w_wr_en;
    logic       r_rd_strobe, w_rd_strobe;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match;
    logic [7:0] w_rx_byte;

    assign io_sda      = r_sda_low ? 1'b0 : 1'bz;
    assign o_reg_addr  = r_reg_addr;
    assign o_wr_en     = r_wr_en;
    assign o_wr_data   = r_wr_data;
    assign o_rd_strobe = r_rd_strobe;
    assign o_busy      = r_busy;

    // Bus event detection on synchronized pins
    assign w_scl_rise   = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall   = ~r_scl_s2 & r_scl_h;
    assign w_start      = r_sda_h & ~r_sda_s2 & r_scl_s2;
    assign w_stop       = ~r_sda_h & r_sda_s2 & r_scl_s2;
    assign w_rx_byte    = {r_shift[6:0], r_sda_s2};
    // General call (address 0) is never acknowledged
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR) && (r_shift[7:1] != 7'd0);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next-state logic; START/STOP take priority over SCL edges
    always_comb begin
        w_state = r_state;
        if (w_start) begin
            w_state = S_ADDR;
        end else if (w_stop) begin
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:  if (w_scl_fall && r_byte_done) w_state = w_addr_match ? S_A_ACK : S_IGNORE;
                S_A_ACK: if (w_scl_fall) w_state = r_rw ? S_RDATA : S_REG;
                S_REG:   if (w_scl_fall && r_byte_done) w_state = S_R_ACK;
                S_R_ACK: if (w_scl_fall) w_state = S_WDATA;
                S_WDATA: if (w_scl_fall && r_byte_done) w_state = S_W_ACK;
                S_W_ACK: if (w_scl_fall) w_state = S_WDATA;
                S_RDATA: if (w_scl_fall && r_byte_done) w_state = S_M_ACK;
                S_M_ACK: begin
                    if (w_scl_rise && r_sda_s2) w_state = S_IGNORE;
                    else if (w_scl_fall && r_byte_done) w_state = S_RDATA;
                end
                default: w_state = r_state;
            endcase
        end
    end

    // Output / datapath next-value logic
    always_comb begin
        w_shift     = r_shift;
        w_tx        = r_tx;
        w_bit_cnt   = r_bit_cnt;
        w_byte_done = r_byte_done;
        w_rw        = r_rw;
        w_sda_low   = r_sda_low;
        w_busy      = r_busy;
        w_reg_addr  = r_reg_addr;
        w_wr_data   = r_wr_data;
        w_wr_en     = 1'b0;
        w_rd_strobe = 1'b0;

        // Read data is captured in the strobe cycle and its MSB put on the bus
        if (r_rd_strobe) begin
            w_tx      = i_rd_data;
            w_sda_low = ~i_rd_data[7];
        end

        if (w_start || w_stop) begin
            w_bit_cnt   = 3'd7;
            w_byte_done = 1'b0;
            w_sda_low   = 1'b0;
            w_busy      = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift = w_rx_byte;
                        if (r_bit_cnt == 3'd0) begin
                            w_byte_done = 1'b1;
                            if (r_state == S_WDATA) begin
                                w_wr_data = w_rx_byte;
                                w_wr_en   = 1'b1;
                            end
                        end else begin
                            w_bit_cnt = r_bit_cnt - 3'd1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done = 1'b0;
                        w_bit_cnt   = 3'd7;
                        if (r_state != S_ADDR) begin
                            w_sda_low = 1'b1;
                        end else if (w_addr_match) begin
                            w_sda_low = 1'b1;
                            w_busy    = 1'b1;
                            w_rw      = r_shift[0];
                        end
                    end
                end
                S_A_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low   = 1'b0;
                        w_bit_cnt   = 3'd7;
                        w_byte_done = 1'b0;
                        w_rd_strobe = r_rw;
                    end
                end
                S_R_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low  = 1'b0;
                        w_reg_addr = r_shift;
                    end
                end
                S_W_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low  = 1'b0;
                        w_reg_addr = r_reg_addr + ADDR_STEP;
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        if (r_bit_cnt == 3'd0) w_byte_done = 1'b1;
                        else w_bit_cnt = r_bit_cnt - 3'd1;
                    end else if (w_scl_fall) begin
                        if (r_byte_done) begin
                            w_sda_low   = 1'b0;
                            w_byte_done = 1'b0;
                        end else begin
                            w_sda_low = ~r_tx[r_bit_cnt];
                        end
                    end
                end
                S_M_ACK: begin
                    if (w_scl_rise) begin
                        w_reg_addr = r_reg_addr + ADDR_STEP;
                        if (r_sda_s2) w_busy = 1'b0;
                        else w_byte_done = 1'b1;
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done = 1'b0;
                        w_bit_cnt   = 3'd7;
                        w_rd_strobe = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizers and datapath registers; pins idle high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_s1    <= 1'b1;
            r_scl_s2    <= 1'b1;
            r_scl_h     <= 1'b1;
            r_sda_s1    <= 1'b1;
            r_sda_s2    <= 1'b1;
            r_sda_h     <= 1'b1;
            r_shift     <= 8'd0;
            r_tx        <= 8'd0;
            r_bit_cnt   <= 3'd7;
            r_byte_done <= 1'b0;
            r_rw        <= 1'b0;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
            r_reg_addr  <= 8'd0;
            r_wr_data   <= 8'd0;
            r_wr_en     <= 1'b0;
            r_rd_strobe <= 1'b0;
        end else begin
            r_scl_s1    <= i_scl;
            r_scl_s2    <= r_scl_s1;
            r_scl_h     <= r_scl_s2;
            r_sda_s1    <= io_sda;
            r_sda_s2    <= r_sda_s1;
            r_sda_h     <= r_sda_s2;
            r_shift     <= w_shift;
            r_tx        <= w_tx;
            r_bit_cnt   <= w_bit_cnt;
            r_byte_done <= w_byte_done;
            r_rw        <= w_rw;
            r_sda_low   <= w_sda_low;
            r_busy      <= w_busy;
            r_reg_addr  <= w_reg_addr;
            r_wr_data   <= w_wr_data;
            r_wr_en     <= w_wr_en;
            r_rd_strobe <= w_rd_strobe;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level master model driving i2c_target, with scoreboard queues for
// expected write strobes and read bytes.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic       wr_en, rd_strobe, busy;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int viol_cnt = 0;
    int dut_low_cnt = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    // Register-file model: contents are a fixed function of the address
    assign rd_data = reg_addr ^ 8'hA5;

    always #5 clk = ~clk;

    i2c_target dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (scl),
        .io_sda      (sda),
        .o_reg_addr  (reg_addr),
        .o_wr_en     (wr_en),
        .o_wr_data   (wr_data),
        .i_rd_data   (rd_data),
        .o_rd_strobe (rd_strobe),
        .o_busy      (busy)
    );

    // Write scoreboard plus strobe width/overlap and target-drive monitors
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst) begin
            if (wr_en) begin
                n_cmp++;
                if (exp_wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", reg_addr, wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({reg_addr, wr_data} !== e) begin
                        n_err++;
                        $display("FAIL wr_value: got addr=%h data=%h, required addr=%h data=%h",
                                 reg_addr, wr_data, e[15:8], e[7:0]);
                    end
                end
            end
            if (rd_strobe) rd_cnt++;
            if ((wr_en && rd_strobe) || (wr_en && prev_wr) || (rd_strobe && prev_rd)) viol_cnt++;
            if (sda === 1'b0 && !m_low) dut_low_cnt++;
        end
        prev_wr = wr_en;
        prev_rd = rd_strobe;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; scl = 1'b1; wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_rstart();
        m_low = 1'b0; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        m_low = 1'b0; wait_clk(Q);
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b; wait_clk(Q);
        scl = 1'b1; wait_clk(2 * Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic get_bit(output logic b);
        m_low = 1'b0; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        b = sda; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic test_reset();
        rst = 1'b1; wait_clk(4);
        rst = 1'b0; wait_clk(2);
        n_cmp++;
        if ({reg_addr, wr_en, wr_data, rd_strobe, busy, sda} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values: got addr=%h wr_en=%b wr_data=%h rd_strobe=%b busy=%b sda=%b, required 00 0 00 0 0 1",
                     reg_addr, wr_en, wr_data, rd_strobe, busy, sda);
        end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        exp_wr_q.push_back({8'h6B, 8'h00});
        bus_start();
        put_byte(8'hD0, a0);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL wr1_busy: got %b, required 1", busy); end
        put_byte(8'h6B, a1);
        put_byte(8'h00, a2);
        bus_stop();
        n_cmp++;
        if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL wr1_acks: got %b, required 000", {a0, a1, a2}); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL wr1_busy_after_p: got %b, required 0", busy); end
        n_cmp++;
        if (reg_addr !== 8'h6C) begin n_err++; $display("FAIL wr1_ptr: got %h, required 6c", reg_addr); end
        n_cmp++;
        if (exp_wr_q.size() != 0) begin
            n_err++; $display("FAIL wr1_missing: %0d writes outstanding, required 0", exp_wr_q.size());
            exp_wr_q.delete();
        end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d, e;
        rd_cnt = 0;
        exp_rd_q.push_back(8'h98);
        exp_rd_q.push_back(8'h9B);
        bus_start();
        put_byte(8'hD0, a0);
        put_byte(8'h3D, a1);
        bus_rstart();
        put_byte(8'hD1, a2);
        n_cmp++;
        if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rd_acks: got %b, required 000", {a0, a1, a2}); end
        for (int i = 0; i < 2; i++) begin
            get_byte(d, (i == 1));
            e = exp_rd_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL rd_byte%0d: got %h, required %h", i, d, e); end
        end
        bus_stop();
        n_cmp++;
        if (rd_cnt !== 2) begin n_err++; $display("FAIL rd_strobes: got %0d, required 2", rd_cnt); end
        n_cmp++;
        if (reg_addr !== 8'h3F) begin n_err++; $display("FAIL rd_ptr: got %h, required 3f", reg_addr); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy: got %b, required 0", busy); end
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        logic b_mid;
        dut_low_cnt = 0;
        bus_start();
        put_byte(8'hA0, a0);
        b_mid = busy;
        put_byte(8'h11, a1);
        bus_stop();
        n_cmp++;
        if ({a0, a1} !== 2'b11) begin n_err++; $display("FAIL mm_acks: got %b, required 11", {a0, a1}); end
        n_cmp++;
        if (dut_low_cnt !== 0) begin n_err++; $display("FAIL mm_sda_driven: got %0d cycles, required 0", dut_low_cnt); end
        n_cmp++;
        if ({b_mid, busy} !== 2'b00) begin n_err++; $display("FAIL mm_busy: got %b, required 00", {b_mid, busy}); end
    endtask

    task automatic test_burst_wrap();
        logic a;
        logic [7:0] d;
        logic [3:0] acks;
        exp_wr_q.push_back({8'hFE, 8'h11});
        exp_wr_q.push_back({8'hFF, 8'h22});
        exp_wr_q.push_back({8'h00, 8'h33});
        bus_start();
        put_byte(8'hD0, a);  acks[0] = a;
        put_byte(8'hFE, a);  acks[1] = a;
        for (int i = 0; i < 3; i++) begin
            d = 8'(8'h11 * (i + 1));
            put_byte(d, a);
            acks[i] = acks[i] | a;
        end
        bus_stop();
        n_cmp++;
        if (acks !== 4'b0000) begin n_err++; $display("FAIL burst_acks: got %b, required 0000", acks); end
        n_cmp++;
        if (reg_addr !== 8'h01) begin n_err++; $display("FAIL burst_ptr: got %h, required 01", reg_addr); end
        n_cmp++;
        if (exp_wr_q.size() != 0) begin
            n_err++; $display("FAIL burst_missing: %0d writes outstanding, required 0", exp_wr_q.size());
            exp_wr_q.delete();
        end
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1, a2, a3;
        bus_start();
        put_byte(8'hD0, a0);
        put_byte(8'h20, a1);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        bus_stop();
        wait_clk(4);
        n_cmp++;
        if ({busy, sda, reg_addr} !== {1'b0, 1'b1, 8'h20}) begin
            n_err++;
            $display("FAIL stopmid_state: got busy=%b sda=%b ptr=%h, required 0 1 20", busy, sda, reg_addr);
        end
        exp_wr_q.push_back({8'h21, 8'h5A});
        bus_start();
        put_byte(8'hD0, a2);
        put_byte(8'h21, a3);
        put_byte(8'h5A, a3);
        bus_stop();
        n_cmp++;
        if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL stopmid_acks: got %b, required 0000", {a0, a1, a2, a3}); end
        n_cmp++;
        if (exp_wr_q.size() != 0) begin
            n_err++; $display("FAIL stopmid_missing: %0d writes outstanding, required 0", exp_wr_q.size());
            exp_wr_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] addr_byte;
        logic a;
        addr_byte = 8'hD0;
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(addr_byte[i]);
        m_low = 1'b0;
        wait_clk(2);
        n_cmp++;
        if (sda !== 1'b0) begin n_err++; $display("FAIL rstmid_ack_hold: got sda=%b, required 0", sda); end
        rst = 1'b1;
        wait_clk(1);
        n_cmp++;
        if (sda !== 1'b1) begin n_err++; $display("FAIL rstmid_release: got sda=%b, required 1", sda); end
        n_cmp++;
        if ({reg_addr, wr_en, wr_data, rd_strobe, busy} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_outputs: got addr=%h wr_en=%b wr_data=%h rd_strobe=%b busy=%b, required 00 0 00 0 0",
                     reg_addr, wr_en, wr_data, rd_strobe, busy);
        end
        rst = 1'b0;
        wait_clk(2);
        bus_stop();
        bus_start();
        put_byte(8'hD0, a);
        bus_stop();
        n_cmp++;
        if (a !== 1'b0) begin n_err++; $display("FAIL rstmid_recover_ack: got %b, required 0", a); end
    endtask

    task automatic test_back_to_back();
        logic a;
        logic [6:0] acks;
        exp_wr_q.push_back({8'h40, 8'hAA});
        exp_wr_q.push_back({8'h80, 8'hBB});
        exp_wr_q.push_back({8'h81, 8'hCC});
        bus_start();
        put_byte(8'hD0, a); acks[0] = a;
        put_byte(8'h40, a); acks[1] = a;
        put_byte(8'hAA, a); acks[2] = a;
        bus_rstart();
        put_byte(8'hD0, a); acks[3] = a;
        put_byte(8'h80, a); acks[4] = a;
        put_byte(8'hBB, a); acks[5] = a;
        put_byte(8'hCC, a); acks[6] = a;
        bus_stop();
        n_cmp++;
        if (acks !== 7'd0) begin n_err++; $display("FAIL b2b_acks: got %b, required 0000000", acks); end
        n_cmp++;
        if (reg_addr !== 8'h82) begin n_err++; $display("FAIL b2b_ptr: got %h, required 82", reg_addr); end
        n_cmp++;
        if (exp_wr_q.size() != 0) begin
            n_err++; $display("FAIL b2b_missing: %0d writes outstanding, required 0", exp_wr_q.size());
            exp_wr_q.delete();
        end
        n_cmp++;
        if (viol_cnt !== 0) begin n_err++; $display("FAIL strobe_shape: got %0d violations, required 0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_mismatch();
        test_burst_wrap();
        test_stop_mid_byte();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
